// File: rtl/bus_arb_if.sv
// Shared bus bundle for the two-master arbiter: data (D) and instruction (I) master
// ports, the shared slave port and the grant vector, named from the arbiter's side.
`default_nettype none

interface bus_arb_if;
  logic [31:0] adrD_i, datD_i, datD_o;
  logic        wenD_i, stbD_i, cycD_i;
  logic [3:0]  selD_i;
  logic        ackD_o, errD_o, rtyD_o;

  logic [31:0] adrI_i, datI_i, datI_o;
  logic        wenI_i, stbI_i, cycI_i;
  logic [3:0]  selI_i;
  logic        ackI_o, errI_o, rtyI_o;

  logic [31:0] adr_o, dat_o, dat_i;
  logic        wen_o, stb_o, cyc_o;
  logic [3:0]  sel_o;
  logic        ack_i, err_i, rty_i;

  logic [1:0]  gnt_o;

  // Arbiter view
  modport slave (
    input  adrD_i, datD_i, wenD_i, stbD_i, cycD_i, selD_i,
    output datD_o, ackD_o, errD_o, rtyD_o,
    input  adrI_i, datI_i, wenI_i, stbI_i, cycI_i, selI_i,
    output datI_o, ackI_o, errI_o, rtyI_o,
    output adr_o, dat_o, wen_o, stb_o, cyc_o, sel_o,
    input  dat_i, ack_i, err_i, rty_i,
    output gnt_o
  );

  // Environment view (masters plus shared slave)
  modport master (
    output adrD_i, datD_i, wenD_i, stbD_i, cycD_i, selD_i,
    input  datD_o, ackD_o, errD_o, rtyD_o,
    output adrI_i, datI_i, wenI_i, stbI_i, cycI_i, selI_i,
    input  datI_o, ackI_o, errI_o, rtyI_o,
    input  adr_o, dat_o, wen_o, stb_o, cyc_o, sel_o,
    output dat_i, ack_i, err_i, rty_i,
    input  gnt_o
  );
endinterface

`default_nettype wire

// File: rtl/bus_arb.sv
// Two-master (data/instruction) bus arbiter with alternating priority, cycle-long
// ownership and a watchdog that forces an error on a stalled slave.
`default_nettype none

module bus_arb #(
  parameter int TIMEOUT = 15
) (
  input  logic      clk,
  input  logic      reset,
  bus_arb_if.slave  bus
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_GNT_D = 2'd1;
  localparam logic [1:0] c_GNT_I = 2'd2;

  logic [1:0] r_state, w_next;
  logic       r_last_d;
  logic [7:0] r_wdog;
  logic       w_stb, w_cyc, w_resp, w_timeout;

  always_comb begin
    w_stb = 1'b0;
    w_cyc = 1'b0;
    case (r_state)
      c_GNT_D: begin w_stb = bus.stbD_i; w_cyc = bus.cycD_i; end
      c_GNT_I: begin w_stb = bus.stbI_i; w_cyc = bus.cycI_i; end
      default: ;
    endcase
  end

  assign w_resp    = bus.ack_i | bus.err_i | bus.rty_i;
  assign w_timeout = (r_state != c_IDLE) && (r_wdog == 8'(TIMEOUT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        // On contention the master not served most recently wins
        if (bus.cycD_i && bus.cycI_i) w_next = r_last_d ? c_GNT_I : c_GNT_D;
        else if (bus.cycD_i)          w_next = c_GNT_D;
        else if (bus.cycI_i)          w_next = c_GNT_I;
      end
      c_GNT_D, c_GNT_I: if (!w_cyc) w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_d <= 1'b0;
      r_wdog   <= 8'd0;
    end else begin
      if (r_state == c_IDLE && w_next == c_GNT_D)      r_last_d <= 1'b1;
      else if (r_state == c_IDLE && w_next == c_GNT_I) r_last_d <= 1'b0;

      if (r_state == c_IDLE || w_timeout || w_resp) r_wdog <= 8'd0;
      else if (w_stb)                               r_wdog <= r_wdog + 8'd1;
    end
  end

  always_comb begin
    bus.gnt_o  = 2'b00;
    bus.adr_o  = 32'd0;
    bus.dat_o  = 32'd0;
    bus.wen_o  = 1'b0;
    bus.sel_o  = 4'd0;
    bus.stb_o  = 1'b0;
    bus.cyc_o  = 1'b0;
    bus.datD_o = 32'd0;
    bus.ackD_o = 1'b0;
    bus.errD_o = 1'b0;
    bus.rtyD_o = 1'b0;
    bus.datI_o = 32'd0;
    bus.ackI_o = 1'b0;
    bus.errI_o = 1'b0;
    bus.rtyI_o = 1'b0;
    case (r_state)
      c_GNT_D: begin
        bus.gnt_o  = 2'b10;
        bus.adr_o  = bus.adrD_i;
        bus.dat_o  = bus.datD_i;
        bus.wen_o  = bus.wenD_i;
        bus.sel_o  = bus.selD_i;
        bus.stb_o  = bus.stbD_i & ~w_timeout;
        bus.cyc_o  = bus.cycD_i;
        bus.datD_o = bus.dat_i;
        bus.ackD_o = bus.ack_i & ~w_timeout;
        bus.errD_o = bus.err_i | w_timeout;
        bus.rtyD_o = bus.rty_i;
      end
      c_GNT_I: begin
        bus.gnt_o  = 2'b01;
        bus.adr_o  = bus.adrI_i;
        bus.dat_o  = bus.datI_i;
        bus.wen_o  = bus.wenI_i;
        bus.sel_o  = bus.selI_i;
        bus.stb_o  = bus.stbI_i & ~w_timeout;
        bus.cyc_o  = bus.cycI_i;
        bus.datI_o = bus.dat_i;
        bus.ackI_o = bus.ack_i & ~w_timeout;
        bus.errI_o = bus.err_i | w_timeout;
        bus.rtyI_o = bus.rty_i;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_arb.sv
// Self-checking bench for bus_arb: random and directed stimulus, reference model, scoreboard.
`default_nettype none

module tb_bus_arb;
  localparam int TO = 4;
  typedef logic [142:0] vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t exp_q[$];

  always #5 clk = ~clk;

  bus_arb_if bus();

  bus_arb #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Reference model: who owns the bus, strobes since the last slave reply, who was served last
  int owner  = 0;  // 0 none, 1 D, 2 I
  int quiet  = 0;
  bit last_d = 1'b0;

  function automatic vec_t actual();
    return {bus.gnt_o, bus.adr_o, bus.dat_o, bus.wen_o, bus.sel_o, bus.stb_o, bus.cyc_o,
            bus.datD_o, bus.ackD_o, bus.errD_o, bus.rtyD_o,
            bus.datI_o, bus.ackI_o, bus.errI_o, bus.rtyI_o};
  endfunction

  function automatic vec_t model_out();
    logic [1:0] g = '0; logic [31:0] a = '0, d = '0, dD = '0, dI = '0;
    logic w = 0, s = 0, c = 0, aD = 0, eD = 0, rD = 0, aI = 0, eI = 0, rI = 0;
    logic [3:0] sl = '0;
    bit to;
    to = (owner != 0) && (quiet == TO);
    if (!reset && owner == 1) begin
      g = 2'b10; a = bus.adrD_i; d = bus.datD_i; w = bus.wenD_i; sl = bus.selD_i;
      s = bus.stbD_i && !to; c = bus.cycD_i; dD = bus.dat_i;
      aD = bus.ack_i && !to; eD = bus.err_i || to; rD = bus.rty_i;
    end else if (!reset && owner == 2) begin
      g = 2'b01; a = bus.adrI_i; d = bus.datI_i; w = bus.wenI_i; sl = bus.selI_i;
      s = bus.stbI_i && !to; c = bus.cycI_i; dI = bus.dat_i;
      aI = bus.ack_i && !to; eI = bus.err_i || to; rI = bus.rty_i;
    end
    return {g, a, d, w, sl, s, c, dD, aD, eD, rD, dI, aI, eI, rI};
  endfunction

  task automatic model_next();
    bit cyc, stb, resp;
    resp = bus.ack_i || bus.err_i || bus.rty_i;
    if (reset) begin
      owner = 0; quiet = 0; last_d = 1'b0;
    end else if (owner == 0) begin
      quiet = 0;
      if (bus.cycD_i && bus.cycI_i) owner = last_d ? 2 : 1;
      else if (bus.cycD_i)          owner = 1;
      else if (bus.cycI_i)          owner = 2;
      if (owner == 1) last_d = 1'b1;
      else if (owner == 2) last_d = 1'b0;
    end else begin
      cyc = (owner == 1) ? bus.cycD_i : bus.cycI_i;
      stb = (owner == 1) ? bus.stbD_i : bus.stbI_i;
      if (!cyc) begin owner = 0; quiet = 0; end
      else if (quiet == TO || resp) quiet = 0;
      else if (stb) quiet = quiet + 1;
    end
  endtask

  task automatic set_in(input bit cD, sD, cI, sI, ak, er, ry);
    bus.adrD_i = $urandom; bus.datD_i = $urandom; bus.wenD_i = 1'($urandom);
    bus.selD_i = 4'($urandom); bus.cycD_i = cD; bus.stbD_i = sD;
    bus.adrI_i = $urandom; bus.datI_i = $urandom; bus.wenI_i = 1'($urandom);
    bus.selI_i = 4'($urandom); bus.cycI_i = cI; bus.stbI_i = sI;
    bus.dat_i = $urandom; bus.ack_i = ak; bus.err_i = er; bus.rty_i = ry;
  endtask

  // Called at posedge+1; applies inputs for one cycle and records the expected response
  task automatic step(input bit cD, sD, cI, sI, ak, er, ry);
    set_in(cD, sD, cI, sI, ak, er, ry);
    exp_q.push_back(model_out());
    model_next();
    @(posedge clk); #1;
  endtask

  task automatic direct_check(input string name, input vec_t exp);
    vec_t a;
    a = actual();
    checks++;
    if (a !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, a, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t e, a;
      e = exp_q.pop_front();
      a = actual();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t got=%h exp=%h", $time, a, e);
      end
    end
  end

  initial begin
    int grants, held, prev_owner;
    logic [1:0] prev_gnt;
    bit cD, cI;

    set_in(1, 1, 1, 1, 1, 1, 1);
    repeat (2) @(posedge clk);
    #1 direct_check("reset_state", '0);
    reset = 1'b0;

    // V1: simultaneous request after reset goes to D, then I after an idle cycle
    step(1, 0, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 1, 1);  // response while idle is dropped

    // V2: D ack on its 3rd strobe, I requesting meanwhile
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 1, 0, 0);
    step(1, 1, 1, 0, 1, 1, 0);  // back-to-back strobe, ack and err together
    step(0, 0, 1, 0, 0, 0, 0);

    // V3: I stalls, watchdog fires on the 5th strobed cycle and again later
    step(0, 0, 1, 1, 0, 0, 0);
    repeat (12) step(0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // V4: I holds for 10 cycles while D waits
    step(0, 0, 1, 1, 0, 0, 0);
    repeat (10) step(1, 1, 1, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 0, 0);

    // V5: asynchronous reset mid-transfer with a slave ack present
    step(1, 1, 1, 1, 0, 0, 0);
    set_in(1, 1, 1, 1, 1, 0, 0);
    #2 reset = 1'b1;
    #1 direct_check("async_reset", '0);
    exp_q.push_back(model_out());
    model_next();
    @(posedge clk); #1;
    step(1, 1, 1, 1, 1, 0, 0);
    reset = 1'b0;
    step(1, 1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // V6: both masters keep requesting; grants must alternate
    grants = 0; held = 0; prev_owner = 0; prev_gnt = 2'b00;
    for (int k = 0; k < 80 && grants < 8; k++) begin
      cD = !(owner == 1 && held >= 2);
      cI = !(owner == 2 && held >= 2);
      prev_owner = owner;
      step(cD, 1, cI, 1, 1'($urandom), 0, 0);
      if (owner != 0 && owner == prev_owner) held++;
      else if (owner != 0) begin
        held = 1;
        grants++;
        if (prev_gnt != 2'b00) begin
          checks++;
          if (bus.gnt_o !== ~prev_gnt) begin
            errors++;
            $display("FAIL alternate got=%b exp=%b", bus.gnt_o, ~prev_gnt);
          end
        end
        prev_gnt = bus.gnt_o;
      end
    end
    checks++;
    if (grants < 8) begin
      errors++;
      $display("FAIL alternate_count got=%0d exp=8", grants);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Random traffic
    cD = 0; cI = 0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) cD = !cD;
      if ($urandom_range(0, 3) == 0) cI = !cI;
      step(cD, 1'($urandom), cI, 1'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end
    step(0, 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
